fpu_issue_seq: RTL and testbench
================================

Name: fpu_issue_seq

Overview:
- Issue/return sequencer directly upstream and downstream of the fixed-latency fpu core.
- Accepts operand requests on a valid/ready interface and drives the fpu's A/B/opcode.
- Tracks each operation through the fpu's LATENCY-cycle pipeline, captures O, and returns the tagged result through a response FIFO with backpressure.
- Credit-based admission guarantees no result is ever lost.

Parameters:
- LATENCY, 3, fpu clock edges from input presentation to valid O (>=1).
- RSP_DEPTH, 4, response FIFO entries; also the max outstanding ops (>=LATENCY recommended for full throughput).
- TAG_W, 4, request tag width.
- OP_W, 2, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_a  in  32  fp32 operand A.
- req_b  in  32  fp32 operand B.
- req_op  in  OP_W  opcode.
- req_tag  in  TAG_W  caller tag.
- fpu_a  out  32  to fpu A.
- fpu_b  out  32  to fpu B.
- fpu_opcode  out  OP_W  to fpu opcode.
- fpu_o  in  32  from fpu O.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_result  out  32  fpu result.
- rsp_tag  out  TAG_W  tag of the request.
- rsp_op  out  OP_W  opcode of the request.
- busy  out  1  any op in flight or queued.
- cnt_issued  out  16  accepted requests, wraps mod 2^16.
- cnt_done  out  16  delivered responses, wraps mod 2^16.

Behaviour:
- Reset (async assert, sync release). All of these clear to 0: fpu_a, fpu_b, fpu_opcode, the in-flight pipeline, the FIFO, rsp_*, busy, and both counters. req_ready goes 1 on the first cycle after release.
- Reset mid-operation discards all in-flight and queued ops. Results arriving from the fpu after release are ignored, because the shadow pipeline is empty.
- Accept: edge E where req_valid && req_ready.
  - At E, fpu_a/fpu_b/fpu_opcode register req_a/req_b/req_op.
  - A shadow shift register of depth LATENCY takes {1, req_tag, req_op} at stage 0.
  - With no accept, the fpu_* outputs hold their values and stage 0 takes valid=0.
- Completion: at edge E+LATENCY the shadow output stage is valid, and fpu_o is written into the FIFO with its tag and op. From the following cycle rsp_valid=1 (FIFO non-empty). Accept-to-response latency is therefore exactly LATENCY cycles with an empty FIFO.
- Response: rsp_* show the FIFO head. An edge with rsp_valid && rsp_ready pops. Order is strictly FIFO, matching issue order.
- Credit: occupancy = inflight_count + fifo_count. req_ready = (occupancy < RSP_DEPTH), computed from registers only; there is no combinational path from rsp_ready or req_valid.
  - A pop frees its credit from the next cycle.
  - Push and pop on the same edge are legal at any occupancy, including a full FIFO. Overflow is impossible by construction.
- Counters: cnt_issued increments on accept, cnt_done on pop, both wrapping 0xFFFF->0x0000.
- busy = (occupancy != 0).
- Throughput: one accept per cycle while credits remain. rsp_ready held low stalls admission after RSP_DEPTH outstanding ops.
- Assertions (bench): fifo never pushed when full; never popped when empty; inflight_count equals the popcount of the shadow valids.

Decomposition:
- Package fpu_seq_pkg holds:
  - opcode enum: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - fp32 constants FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_THREE=32'h40400000;
  - the packed in-flight entry typedef {valid, tag, op}.
- One sub-module: seq_fifo, a parameterised synchronous FIFO of width 32+TAG_W+OP_W and depth RSP_DEPTH with count output.

Test Plan:
- Single op: after reset, request A=0x3F800000, B=0x40000000, op=ADD, tag=5.
  - Required: fpu_a=0x3F800000 after the accept edge.
  - Required: rsp_valid rises 3 cycles after accept with rsp_result=0x40400000, rsp_tag=5.
  - Required: cnt_issued=1 and cnt_done=1 after the pop.
- Back-to-back: 4 requests on consecutive cycles (tags 0..3, ADD/SUB/MUL/DIV of 3.0,1.0), rsp_ready=1.
  - Required: responses on 4 consecutive cycles in tag order with results 0x40800000, 0x40000000, 0x40400000, 0x40400000.
- Backpressure: rsp_ready=0, req_valid held high.
  - Required: exactly 4 accepts, then req_ready=0 and busy=1.
  - Raise rsp_ready for one cycle -> one pop, then req_ready=1 the next cycle, and one further accept.
- Simultaneous push/pop at full: FIFO holding 3 entries plus 1 in flight; completion and pop coincide.
  - Required: fifo_count unchanged, no data loss, tag order preserved.
- Reset mid-flight: assert rst_n=0 with 2 in flight and 1 queued.
  - Required: rsp_valid=0, busy=0, counters=0 immediately.
  - Required: after release, no spurious response for 10 cycles.
- Counter wrap: force 65536 accepts/pops -> cnt_issued and cnt_done read 0x0000.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the fpu issue/return sequencer.
package fpu_seq_pkg;

  localparam int SEQ_TAG_W = 4;
  localparam int SEQ_OP_W  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fpu_op_e;

  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [31:0] FP_THREE = 32'h4040_0000;

  typedef struct packed {
    logic                 valid;
    logic [SEQ_TAG_W-1:0] tag;
    logic [SEQ_OP_W-1:0]  op;
  } inflight_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at any fill level.
module seq_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage is cleared so the response bus reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue/return sequencer around a fixed-latency fpu: credit-based admission,
// shadow pipeline tracking tag/op, and a response FIFO with backpressure.
module fpu_issue_seq
  import fpu_seq_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = SEQ_TAG_W,
  parameter int OP_W      = SEQ_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [OP_W-1:0]  fpu_opcode,
  input  logic [31:0]      fpu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [OP_W-1:0]  rsp_op,
  output logic             busy,
  output logic [15:0]      cnt_issued,
  output logic [15:0]      cnt_done
);

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int FW    = 32 + TAG_W + OP_W;
  localparam logic [OCC_W:0] DEPTH_V = (OCC_W + 1)'(RSP_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [OP_W-1:0]  op;
  } stage_t;

  stage_t             sh [LATENCY];
  logic [LATENCY-1:0] sh_valid;
  logic [OCC_W-1:0]   inflight_cnt;
  logic [OCC_W-1:0]   fifo_count;
  logic [OCC_W:0]     occ;
  logic [OCC_W:0]     occ_next;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_wdata;
  logic [FW-1:0]      fifo_rdata;

  assign accept     = req_valid & req_ready;
  assign push       = sh[LATENCY-1].valid;
  assign rsp_valid  = ~fifo_empty;
  assign pop        = rsp_valid & rsp_ready;
  assign fifo_wdata = {fpu_o, sh[LATENCY-1].tag, sh[LATENCY-1].op};
  assign {rsp_result, rsp_tag, rsp_op} = fifo_rdata;

  // Occupancy is built from registers only; a completion moves an op from
  // the pipeline to the FIFO without changing the total.
  assign occ      = {1'b0, inflight_cnt} + {1'b0, fifo_count};
  assign occ_next = occ + (OCC_W + 1)'(accept) - (OCC_W + 1)'(pop);

  always_comb begin
    sh_valid = '0;
    for (int i = 0; i < LATENCY; i++) sh_valid[i] = sh[i].valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_opcode   <= '0;
      for (int i = 0; i < LATENCY; i++) sh[i] <= '0;
      inflight_cnt <= '0;
      req_ready    <= 1'b0;
      busy         <= 1'b0;
      cnt_issued   <= '0;
      cnt_done     <= '0;
    end else begin
      if (accept) begin
        fpu_a      <= req_a;
        fpu_b      <= req_b;
        fpu_opcode <= req_op;
      end
      sh[0] <= {accept, req_tag, req_op};
      for (int i = 1; i < LATENCY; i++) sh[i] <= sh[i-1];
      inflight_cnt <= inflight_cnt + OCC_W'(accept) - OCC_W'(push);
      req_ready    <= (occ_next < DEPTH_V);
      busy         <= (occ_next != '0);
      if (accept) cnt_issued <= cnt_issued + 16'd1;
      if (pop)    cnt_done   <= cnt_done + 16'd1;
    end
  end

  seq_fifo #(
    .W     (FW),
    .DEPTH (RSP_DEPTH),
    .CW    (OCC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq with a small 3-stage fpu model on fpu_o.
module tb_fpu_issue_seq;
  import fpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_op;
  logic [3:0]  req_tag;
  logic [31:0] fpu_a, fpu_b, fpu_o;
  logic [1:0]  fpu_opcode;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [1:0]  rsp_op;
  logic        busy;
  logic [15:0] cnt_issued, cnt_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_issue_seq #(.LATENCY(3), .RSP_DEPTH(4), .TAG_W(4), .OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_op(rsp_op),
    .busy(busy), .cnt_issued(cnt_issued), .cnt_done(cnt_done)
  );

  // fpu stand-in: result of the inputs registered at edge E appears on fpu_o
  // in time to be sampled at edge E+3.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (a == FP_ONE && b == FP_TWO && op == OP_ADD) return FP_THREE;
    if (a == FP_THREE && b == FP_ONE) begin
      case (op)
        OP_ADD:  return 32'h4080_0000;
        OP_SUB:  return FP_TWO;
        default: return FP_THREE;
      endcase
    end
    return a ^ b ^ {30'd0, op};
  endfunction

  logic [31:0] fp_r0 = '0;
  logic [31:0] fp_r1 = '0;
  always @(posedge clk) begin
    fp_r0 <= fpu_model(fpu_a, fpu_b, fpu_opcode);
    fp_r1 <= fp_r0;
  end
  assign fpu_o = fp_r1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(dut.u_fifo.push && dut.u_fifo.full))
        else $error("FAIL fifo_push_when_full");
      assert (!(dut.u_fifo.pop && dut.u_fifo.empty))
        else $error("FAIL fifo_pop_when_empty");
      assert (int'(dut.inflight_cnt) == $countones(dut.sh_valid))
        else $error("FAIL inflight_popcount got %0d exp %0d", dut.inflight_cnt, $countones(dut.sh_valid));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0;
    cyc(); cyc();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    n_cmp++; if (fpu_a !== 32'h0) begin n_bad++; $display("FAIL reset_fpu_a got %h exp 0", fpu_a); end
    n_cmp++; if (cnt_issued !== 16'h0 || cnt_done !== 16'h0) begin n_bad++; $display("FAIL reset_counters got %h/%h exp 0/0", cnt_issued, cnt_done); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_a = FP_ONE; req_b = FP_TWO; req_op = OP_ADD; req_tag = 4'd5;
    cyc();
    req_valid = 1'b0;
    n_cmp++; if (fpu_a !== FP_ONE) begin n_bad++; $display("FAIL single_fpu_a got %h exp %h", fpu_a, FP_ONE); end
    n_cmp++; if (fpu_b !== FP_TWO) begin n_bad++; $display("FAIL single_fpu_b got %h exp %h", fpu_b, FP_TWO); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b exp 1", busy); end
    cyc();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_1 got %b exp 0", rsp_valid); end
    cyc();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_2 got %b exp 0", rsp_valid); end
    cyc();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
    n_cmp++; if (rsp_result !== FP_THREE) begin n_bad++; $display("FAIL single_result got %h exp %h", rsp_result, FP_THREE); end
    n_cmp++; if (rsp_tag !== 4'd5 || rsp_op !== OP_ADD) begin n_bad++; $display("FAIL single_tag_op got %h/%h exp 5/0", rsp_tag, rsp_op); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    n_cmp++; if (cnt_issued !== 16'd1 || cnt_done !== 16'd1) begin n_bad++; $display("FAIL single_counters got %0d/%0d exp 1/1", cnt_issued, cnt_done); end
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b/%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [4];
    exp_r[0] = 32'h4080_0000; exp_r[1] = 32'h4000_0000;
    exp_r[2] = 32'h4040_0000; exp_r[3] = 32'h4040_0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_a = FP_THREE; req_b = FP_ONE; req_op = 2'(i); req_tag = 4'(i);
      cyc();
    end
    req_valid = 1'b0;
    n_cmp++; if (fpu_opcode !== OP_DIV) begin n_bad++; $display("FAIL b2b_last_opcode got %0d exp 3", fpu_opcode); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'(k) || rsp_result !== exp_r[k])
        begin n_bad++; $display("FAIL b2b_rsp%0d got v=%b tag=%0d res=%h exp v=1 tag=%0d res=%h", k, rsp_valid, rsp_tag, rsp_result, k, exp_r[k]); end
      cyc();
    end
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got %b/%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_backpressure();
    int   n_acc;
    logic rdy;
    n_acc = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_a = FP_ONE; req_b = FP_TWO; req_op = OP_ADD; req_tag = 4'd8;
    for (int i = 0; i < 10; i++) begin
      rdy = req_ready;
      cyc();
      if (rdy) begin n_acc++; req_tag = 4'(8 + n_acc); end
    end
    n_cmp++; if (n_acc != 4) begin n_bad++; $display("FAIL bp_accepts got %0d exp 4", n_acc); end
    n_cmp++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL bp_stalled got ready=%b busy=%b exp 0/1", req_ready, busy); end
    n_cmp++; if (rsp_tag !== 4'd8) begin n_bad++; $display("FAIL bp_head got %0d exp 8", rsp_tag); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_credit_back got %b exp 1", req_ready); end
    cyc();
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0 || cnt_issued !== 16'd10) begin n_bad++; $display("FAIL bp_refill got ready=%b issued=%0d exp 0/10", req_ready, cnt_issued); end
    n_cmp++; if (rsp_tag !== 4'd9) begin n_bad++; $display("FAIL bp_head2 got %0d exp 9", rsp_tag); end
  endtask

  // Continues from backpressure: tags 9,10,11 queued, tag 12 completing two edges later.
  task automatic test_full_push_pop();
    cyc(); cyc();
    n_cmp++; if (dut.u_fifo.count !== 3'd3) begin n_bad++; $display("FAIL fp_count_before got %0d exp 3", dut.u_fifo.count); end
    n_cmp++; if (dut.inflight_cnt !== 3'd1) begin n_bad++; $display("FAIL fp_inflight got %0d exp 1", dut.inflight_cnt); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    n_cmp++; if (dut.u_fifo.count !== 3'd3) begin n_bad++; $display("FAIL fp_count_after got %0d exp 3", dut.u_fifo.count); end
    n_cmp++; if (rsp_tag !== 4'd10 || req_ready !== 1'b1) begin n_bad++; $display("FAIL fp_head got tag=%0d ready=%b exp 10/1", rsp_tag, req_ready); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'(10 + k) || rsp_result !== FP_THREE)
        begin n_bad++; $display("FAIL fp_drain%0d got v=%b tag=%0d res=%h exp v=1 tag=%0d res=%h", k, rsp_valid, rsp_tag, rsp_result, 10 + k, FP_THREE); end
      cyc();
    end
    rsp_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || cnt_done !== 16'd10) begin n_bad++; $display("FAIL fp_end got busy=%b done=%0d exp 0/10", busy, cnt_done); end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    req_a = FP_ONE; req_b = FP_TWO; req_op = OP_ADD;
    req_valid = 1'b1; req_tag = 4'd1; cyc();
    req_valid = 1'b0; cyc();
    req_valid = 1'b1; req_tag = 4'd2; cyc();
    req_tag = 4'd3; cyc();
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || dut.inflight_cnt !== 3'd2) begin n_bad++; $display("FAIL mid_setup got v=%b inflight=%0d exp 1/2", rsp_valid, dut.inflight_cnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_clear got v=%b busy=%b exp 0/0", rsp_valid, busy); end
    n_cmp++; if (cnt_issued !== 16'd0 || cnt_done !== 16'd0) begin n_bad++; $display("FAIL mid_counters got %0d/%0d exp 0/0", cnt_issued, cnt_done); end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_spurious cycle %0d got %b exp 0", i, rsp_valid); end
    end
    n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_idle got busy=%b ready=%b exp 0/1", busy, req_ready); end
  endtask

  task automatic test_counter_wrap();
    int   acc;
    logic rdy;
    acc = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = FP_ONE; req_b = FP_TWO; req_op = OP_ADD; req_tag = 4'd0;
    for (int i = 0; i < 90000 && acc < 65536; i++) begin
      rdy = req_ready;
      cyc();
      if (rdy) begin
        acc++;
        if (acc == 65535) begin
          n_cmp++; if (cnt_issued !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre got %h exp ffff", cnt_issued); end
        end
        if (acc == 65536) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (acc != 65536) begin n_bad++; $display("FAIL wrap_accepts got %0d exp 65536", acc); end
    for (int i = 0; i < 20 && busy; i++) cyc();
    rsp_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_drain got busy=%b v=%b exp 0/0", busy, rsp_valid); end
    n_cmp++; if (cnt_issued !== 16'h0000 || cnt_done !== 16'h0000) begin n_bad++; $display("FAIL wrap_counters got %h/%h exp 0000/0000", cnt_issued, cnt_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_reset_midflight();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
